// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, default width.
package mdu_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MADDU = 3'd5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

endpackage

// File: rtl/mdu_if.sv
// EX-stage request/result bundle between the pipeline and the multiply/divide unit.
interface mdu_if #(parameter int DATA_W = mdu_pkg::DATA_W_DEF);

    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              mthi;
    logic              mtlo;
    logic              flush;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;

    modport master (output start, op, rs_data, rt_data, mthi, mtlo, flush,
                    input  hi, lo, busy, done);
    modport slave  (input  start, op, rs_data, rt_data, mthi, mtlo, flush,
                    output hi, lo, busy, done);

endinterface

// File: rtl/mdu_iter_datapath.sv
// One radix-2 step per cycle on unsigned magnitudes: shift-add multiply or
// restoring shift-subtract divide, sharing one adder and a 2*DATA_W shift register.
module mdu_iter_datapath #(parameter int DATA_W = 32) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic                  div_mode_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic [2*DATA_W-1:0]   acc_o
);
    localparam int W = DATA_W;

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic [W-1:0]   acc_hi, acc_lo;
    logic [W:0]     rem_sh;
    logic [W+1:0]   sum;

    assign acc_hi = acc_q[2*W-1:W];
    assign acc_lo = acc_q[W-1:0];
    assign rem_sh = {acc_hi, acc_lo[W-1]};
    assign acc_o  = acc_q;

    always_comb begin
        if (div_mode_i) sum = {1'b0, rem_sh} - {2'b00, opnd_q};
        else            sum = {2'b00, acc_hi} + {2'b00, opnd_q};
        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (load_i) begin
            // Low half starts as multiplier (mul) or dividend (div); quotient bits shift in behind it.
            acc_d  = {{W{1'b0}}, div_mode_i ? a_i : b_i};
            opnd_d = div_mode_i ? b_i : a_i;
        end else if (step_i) begin
            if (div_mode_i)
                acc_d = sum[W+1] ? {rem_sh[W-1:0], acc_lo[W-2:0], 1'b0}
                                 : {sum[W-1:0],    acc_lo[W-2:0], 1'b1};
            else
                acc_d = acc_lo[0] ? {sum[W:0], acc_lo[W-1:1]}
                                  : {1'b0, acc_hi, acc_lo[W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; FSM IDLE->PREP->ITER->FIX.
// Define MDU_MADD_EN to add MADD/MADDU (multiply then accumulate into {HI,LO}).
module mul_div_unit
    import mdu_pkg::*;
#(parameter int DATA_W = DATA_W_DEF) (
    input logic   clk,
    input logic   reset,
    mdu_if.slave  bus
);
    localparam int W  = DATA_W;
    localparam int CW = $clog2(DATA_W);

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q, b_q, hi_q, lo_q;
    logic           neg_res_q, neg_rem_q, divz_q, done_q;

    logic           op_ok, go, is_div, is_signed, sa, sb;
    logic [W-1:0]   a_mag, b_mag, quo, rem;
    logic [2*W-1:0] acc, prod, res;

    always_comb begin
`ifdef MDU_MADD_EN
        op_ok = (bus.op <= OP_MADDU);
`else
        op_ok = (bus.op <= OP_DIVU);
`endif
    end

    assign go        = bus.start && op_ok;
    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign is_signed = !op_q[0];
    assign sa        = is_signed && a_q[W-1];
    assign sb        = is_signed && b_q[W-1];
    assign a_mag     = sa ? -a_q : a_q;
    assign b_mag     = sb ? -b_q : b_q;

    mdu_iter_datapath #(.DATA_W(W)) u_dp (
        .clk        (clk),
        .rst        (reset),
        .load_i     (state_q == S_PREP),
        .step_i     (state_q == S_ITER),
        .div_mode_i (is_div),
        .a_i        (a_mag),
        .b_i        (b_mag),
        .acc_o      (acc)
    );

    always_comb begin
        prod = neg_res_q ? -acc : acc;
        quo  = neg_res_q ? -acc[W-1:0] : acc[W-1:0];
        rem  = neg_rem_q ? -acc[2*W-1:W] : acc[2*W-1:W];
        if (is_div)
            res = divz_q ? {a_q, {W{1'b1}}} : {rem, quo};
`ifdef MDU_MADD_EN
        else if (op_q == OP_MADD || op_q == OP_MADDU)
            res = {hi_q, lo_q} + prod;
`endif
        else
            res = prod;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (go) state_d = S_PREP;
            S_PREP: begin
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) state_d = S_FIX;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= 1'b0;
            if (state_q == S_IDLE) begin
                if (go) begin
                    op_q <= bus.op;
                    a_q  <= bus.rs_data;
                    b_q  <= bus.rt_data;
                end else begin
                    if (bus.mthi) hi_q <= bus.rs_data;
                    if (bus.mtlo) lo_q <= bus.rs_data;
                end
            end
            if (state_q == S_PREP) begin
                neg_res_q <= sa ^ sb;
                neg_rem_q <= sa;
                divz_q    <= (b_q == '0);
            end
            if (state_q == S_FIX && !bus.flush) begin
                {hi_q, lo_q} <= res;
                done_q       <= 1'b1;
            end
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the pipelined MIPS core.
- Consumes the two operands read from the register file (rs/rt data, after forwarding) and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, plus single-cycle MTHI/MTLO writes.
- Raises busy so the hazard unit stalls MFHI/MFLO and any following HI/LO-touching instruction.

Parameters:
DATA_W, 32, operand and HI/LO width. Iteration count equals DATA_W; counter width is clog2(DATA_W).

Ports:
clk  in  1  core clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
start  in  1  launch operation given by op; sampled only in IDLE
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MADD 5=MADDU; 6,7 reserved/ignored
rs_data  in  DATA_W  multiplicand/dividend (register-file read port 1 path)
rt_data  in  DATA_W  multiplier/divisor (read port 2 path)
mthi  in  1  write rs_data to HI
mtlo  in  1  write rs_data to LO
flush  in  1  abort in-flight operation (exception/branch squash)
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse when HI/LO are updated by a completed operation

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal datapath=0. Reset asserted mid-operation discards the operation; no done pulse.
- States: IDLE -> PREP -> ITER -> FIX -> IDLE.
- IDLE: on valid start, latch op, rs_data and rt_data; go to PREP.
- PREP (1 cycle): form operand magnitudes for signed ops; record result sign and remainder sign (= dividend sign). Clear the 64-bit accumulator and the counter.
- ITER (DATA_W cycles):
  - multiply: radix-2 shift-add;
  - divide: restoring shift-subtract;
  - counter 0..DATA_W-1; on the last count go to FIX.
- FIX (1 cycle): apply two's-complement sign correction, write HI/LO, assert done on the transition back to IDLE.
- Latency: start sampled at edge E0; hi/lo and done become valid after edge E(DATA_W+2), i.e. E34 for DATA_W=32. busy=1 from E0 through E(DATA_W+2). done is registered and lasts exactly one cycle.
- Multiply results: HI = upper product, LO = lower product.
- Divide results: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder sign follows the dividend.
- Divide by zero (signed or unsigned): same latency; LO = all ones, HI = rs_data.
- Signed 0x80000000 / -1: LO = 0x80000000, HI = 0 (wrap, no trap).
- Priority when several inputs are active in one cycle: flush > start > mthi/mtlo.
  - flush in any non-IDLE state: go to IDLE next edge; HI/LO unchanged; no done. flush in IDLE has no effect.
  - start while busy is ignored.
  - mthi/mtlo while busy are ignored; the hazard unit guarantees this does not occur.
  - start and mthi/mtlo in the same IDLE cycle: start wins; the move is dropped.
- mthi and mtlo together write both registers in one cycle. Writes land at the next edge.
- Reserved op with start: ignored; stays IDLE.

Optional Feature:
- MDU_MADD_EN defined:
  - op 4 (MADD) and op 5 (MADDU) run the signed/unsigned multiply path.
  - In FIX, the 64-bit product is added to {hi,lo}, modulo 2^64.
  - Same latency as MULT.
- MDU_MADD_EN undefined: op 4/5 are treated as reserved (ignored, no busy, no done). Accumulate logic is not synthesised.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings (OP_MULT..OP_MADDU);
  - state encoding (S_IDLE, S_PREP, S_ITER, S_FIX);
  - DATA_W default.
- One natural sub-module: mdu_iter_datapath. It contains the 64-bit shift register, the DATA_W+1 adder/subtractor and the per-step control. It performs the multiply or divide step selected by a mode input. The parent module holds the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly 34 cycles after start; busy high throughout.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Follow with DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=0x00000064. Then DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0x12345678, then DIVU 50/3, flush asserted 10 cycles after start -> hi stays 0x12345678, done never asserts, busy low after the next edge. A second start pulse during busy is ignored.
- MULTU 5*6 with reset asserted asynchronously at cycle 20 -> hi, lo, busy and done read 0 immediately. A fresh MULTU 5*6 after release -> lo=30, hi=0.
- With MDU_MADD_EN: MTLO 10, then MADDU 4*5 -> lo=30, hi=0. Without the macro, the same stimulus -> lo stays 10, busy never asserts.
